// File: rtl/univ_shift_reg.sv
// Universal register: parallel load plus a start/busy/done sequenced engine that
// applies one shift, rotate or count step per clock for a programmable number of steps.
module univ_shift_reg #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state;
    logic [2:0]       op_lat;
    logic [AMT_W-1:0] cnt;
    logic [WIDTH:0]   nxt;

    // One engine step; result is {ser_out, q}. The reserved op holds both.
    function automatic logic [WIDTH:0] step_fn(
        input logic [2:0]       o,
        input logic [WIDTH-1:0] v,
        input logic             si,
        input logic             so
    );
        logic signed [WIDTH-1:0] asr;
        asr = $signed(v) >>> 1;
        case (o)
            3'b000:  step_fn = {v[WIDTH-1], v[WIDTH-2:0], si};
            3'b001:  step_fn = {v[0], si, v[WIDTH-1:1]};
            3'b010:  step_fn = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            3'b011:  step_fn = {v[0], v[0], v[WIDTH-1:1]};
            3'b100:  step_fn = {v[0], asr};
            3'b101:  step_fn = {&v, v + WIDTH'(1)};
            3'b110:  step_fn = {~|v, v - WIDTH'(1)};
            default: step_fn = {so, v};
        endcase
    endfunction

    assign nxt = step_fn(op_lat, q, ser_in, ser_out);

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state   <= IDLE;
            q       <= '0;
            ser_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            op_lat  <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (load) begin
                        q <= d;
                    end else if (start) begin
                        op_lat <= op;
                        cnt    <= amt;
                        // A zero step count skips straight to the done pulse.
                        if (amt != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    {ser_out, q} <= nxt;
                    cnt          <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: expected results are queued when an operation
// is started and compared when its done pulse appears.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       clear_n, load, start, ser_in;
    logic [3:0] d, amt, q;
    logic [2:0] op;
    logic       ser_out, busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [3:0] q;
        logic       so;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] ref_q;
    logic       ref_so;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(4), .AMT_W(4)) dut (
        .clk(clk), .clear_n(clear_n), .d(d), .load(load), .start(start),
        .op(op), .amt(amt), .ser_in(ser_in), .q(q), .ser_out(ser_out),
        .busy(busy), .done(done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of n steps, written arithmetically.
    task automatic model(input logic [2:0] o, input int n, input logic si,
                         input logic [3:0] v0, input logic so0,
                         output logic [3:0] v, output logic so);
        v  = v0;
        so = so0;
        for (int i = 0; i < n; i++) begin
            case (o)
                3'd0: begin so = v[3]; v = (v << 1) | {3'b000, si}; end
                3'd1: begin so = v[0]; v = (v >> 1) | {si, 3'b000}; end
                3'd2: begin so = v[3]; v = (v << 1) | (v >> 3); end
                3'd3: begin so = v[0]; v = (v >> 1) | (v << 3); end
                3'd4: begin so = v[0]; v = (v >> 1) | (v & 4'b1000); end
                3'd5: begin so = (v == 4'hF); v = v + 4'd1; end
                3'd6: begin so = (v == 4'h0); v = v - 4'd1; end
                default: ;
            endcase
        end
    endtask

    task automatic do_load(input logic [3:0] v);
        d    = v;
        load = 1'b1;
        tick;
        load  = 1'b0;
        ref_q = v;
        check("load q", 8'(q), 8'(v));
        check("load ser_out hold", 8'(ser_out), 8'(ref_so));
    endtask

    // jam drives load/start/op/amt with junk while the engine runs.
    task automatic run_op(input string tag, input logic [2:0] o, input int n,
                          input logic si, input bit jam);
        exp_t       e;
        logic [3:0] eq;
        logic       es;
        int         cyc, bcyc;
        model(o, n, si, ref_q, ref_so, eq, es);
        e.tag = tag; e.q = eq; e.so = es;
        sb.push_back(e);
        ref_q  = eq;
        ref_so = es;
        op     = o;
        amt    = 4'(n);
        ser_in = si;
        start  = 1'b1;
        tick;
        start = 1'b0;
        if (jam) begin
            load  = 1'b1;
            d     = ~eq;
            start = 1'b1;
            op    = 3'($urandom);
            amt   = 4'($urandom);
        end
        cyc  = 0;
        bcyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bcyc++;
            tick;
            cyc++;
        end
        load  = 1'b0;
        start = 1'b0;
        check({tag, " done seen"}, 8'(done), 8'd1);
        check({tag, " busy at done"}, 8'(busy), 8'd0);
        check({tag, " busy cycles"}, 8'(bcyc), 8'(n));
        check({tag, " done latency"}, 8'(cyc), 8'(n));
        if (sb.size() == 0) begin
            check({tag, " scoreboard empty"}, 8'd0, 8'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, " q"}, 8'(q), 8'(e.q));
            check({e.tag, " ser_out"}, 8'(ser_out), 8'(e.so));
        end
        tick;
        check({tag, " done pulse width"}, 8'(done), 8'd0);
        check({tag, " idle busy"}, 8'(busy), 8'd0);
    endtask

    initial begin
        int seen;
        clear_n = 1'b0; load = 1'b1; d = 4'hF; start = 1'b0;
        op = 3'd0; amt = 4'd0; ser_in = 1'b0;
        tick;
        check("reset q", 8'(q), 8'h0);
        check("reset busy", 8'(busy), 8'd0);
        check("reset done", 8'(done), 8'd0);
        check("reset ser_out", 8'(ser_out), 8'd0);
        clear_n = 1'b1; load = 1'b0;
        ref_q = 4'h0; ref_so = 1'b0;

        do_load(4'b1011);
        run_op("rol1", 3'd2, 1, 1'b0, 1'b0);
        check("rol1 literal q", 8'(q), 8'b0111);
        check("rol1 literal so", 8'(ser_out), 8'd1);

        do_load(4'b1000);
        run_op("shr3", 3'd1, 3, 1'b1, 1'b1);
        check("shr3 literal q", 8'(q), 8'b1111);
        check("shr3 literal so", 8'(ser_out), 8'd0);

        do_load(4'b1000);
        run_op("asr5", 3'd4, 5, 1'b0, 1'b1);
        check("asr5 literal q", 8'(q), 8'b1111);
        run_op("dec0", 3'd6, 0, 1'b0, 1'b0);
        check("dec0 literal q", 8'(q), 8'b1111);

        do_load(4'b1110);
        run_op("inc3", 3'd5, 3, 1'b0, 1'b0);
        check("inc3 literal q", 8'(q), 8'b0001);
        check("inc3 literal so", 8'(ser_out), 8'd0);
        do_load(4'b1110);
        run_op("inc2", 3'd5, 2, 1'b0, 1'b0);
        check("inc2 literal q", 8'(q), 8'b0000);
        check("inc2 literal so", 8'(ser_out), 8'd1);

        run_op("dec1", 3'd6, 1, 1'b0, 1'b1);
        check("dec1 literal q", 8'(q), 8'b1111);
        do_load(4'b0110);
        run_op("ror6", 3'd3, 6, 1'b0, 1'b1);
        check("ror6 literal q", 8'(q), 8'b1001);
        run_op("rsv3", 3'd7, 3, 1'b1, 1'b1);
        run_op("shl9", 3'd0, 9, 1'b0, 1'b0);
        check("shl9 literal q", 8'(q), 8'b0000);

        d = 4'd5; load = 1'b1; start = 1'b1; op = 3'd0; amt = 4'd7;
        tick;
        load = 1'b0; start = 1'b0;
        check("load beats start q", 8'(q), 8'h5);
        check("load beats start busy", 8'(busy), 8'd0);
        tick;
        check("load beats start busy2", 8'(busy), 8'd0);
        check("load beats start done", 8'(done), 8'd0);

        op = 3'd0; amt = 4'd7; ser_in = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        check("abort busy", 8'(busy), 8'd1);
        tick;
        tick;
        check("abort mid q", 8'(q), 8'b0111);
        clear_n = 1'b0;
        tick;
        clear_n = 1'b1;
        check("abort q", 8'(q), 8'h0);
        check("abort busy low", 8'(busy), 8'd0);
        check("abort done low", 8'(done), 8'd0);
        check("abort ser_out", 8'(ser_out), 8'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("abort no done", 8'(seen), 8'd0);
        check("scoreboard drained", 8'(sb.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
